// File: rtl/game_state_poller.sv
// game_state_poller: round-robin poller keeping a FIELD_W-bit shadow of NUM_CH memory-mapped words
// Ports: clk/reset (sync, active-high); enable runs sweeps; freeze performs reads without updating
// shadows; ch_mask selects channels (latched at sweep start); mem_addr/mem_re/mem_rdata form the
// synchronous read port; fields holds the shadows; changed pulses per updated channel; sweep_done
// pulses after the last enabled channel; busy is high outside IDLE.
module game_state_poller #(
    parameter int              NUM_CH     = 4,
    parameter int              ADDR_W     = 32,
    parameter int              DATA_W     = 32,
    parameter int              FIELD_W    = 2,
    parameter int              RD_LATENCY = 1,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 'h3000,
    parameter logic [ADDR_W-1:0] STRIDE    = 'h1000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      freeze,
    input  logic [NUM_CH-1:0]         ch_mask,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic                      mem_re,
    input  logic [DATA_W-1:0]         mem_rdata,
    output logic [NUM_CH*FIELD_W-1:0] fields,
    output logic [NUM_CH-1:0]         changed,
    output logic                      sweep_done,
    output logic                      busy
);
    localparam int CW    = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    localparam int WLAST = RD_LATENCY > 1 ? RD_LATENCY - 2 : 0;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CAPTURE} state_t;
    state_t state, state_nx;

    logic [NUM_CH-1:0] mask_q;
    logic [CW-1:0]     ch, first_ch, next_ch;
    logic              first_ok, next_ok;
    logic [1:0]        wcnt;
    logic              unused_bits;

    assign unused_bits = ^mem_rdata;

    // Lowest set bit of the live mask (sweep start) and next set bit above ch in the latched mask.
    always_comb begin
        first_ch = '0;
        first_ok = 1'b0;
        next_ch  = '0;
        next_ok  = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_mask[i]) begin
                first_ch = CW'(i);
                first_ok = 1'b1;
            end
            if (mask_q[i] && i > int'(ch)) begin
                next_ch = CW'(i);
                next_ok = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = enable && first_ok ? ISSUE : IDLE;
            ISSUE:   state_nx = RD_LATENCY > 1 ? WAIT : CAPTURE;
            WAIT:    state_nx = wcnt == 2'(WLAST) ? CAPTURE : WAIT;
            CAPTURE: state_nx = enable && next_ok ? ISSUE : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        mem_re   = state == ISSUE;
        busy     = state != IDLE;
        mem_addr = BASE_ADDR + ADDR_W'(ch) * STRIDE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q     <= '0;
            ch         <= '0;
            wcnt       <= '0;
            fields     <= '0;
            changed    <= '0;
            sweep_done <= 1'b0;
        end else begin
            changed    <= '0;
            sweep_done <= 1'b0;
            wcnt       <= state == WAIT && state_nx == WAIT ? wcnt + 2'd1 : 2'd0;
            if (state == IDLE && state_nx == ISSUE) begin
                mask_q <= ch_mask;
                ch     <= first_ch;
            end
            if (state == CAPTURE) begin
                if (!freeze) begin
                    fields[ch*FIELD_W +: FIELD_W] <= mem_rdata[FIELD_W-1:0];
                    changed[ch] <= fields[ch*FIELD_W +: FIELD_W] != mem_rdata[FIELD_W-1:0];
                end
                if (state_nx == ISSUE) ch <= next_ch;
                // Dropping enable abandons the sweep, so no completion pulse then.
                sweep_done <= enable && !next_ok;
            end
        end
    end
endmodule
